memory: RTL and testbench

- Byte-wide synchronous RAM serving the CPU address space in the NES top level.
- Written by the host loader while the CPU is paused, then read and written by the cpu core during execution.
- One port, shared between the loader and the CPU; the top level muxes the two.
- Registered read data; smaller depths mirror across the full 16-bit address space.

---
 rtl/memory.sv | 72 +++++++
 tb/tb_memory.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/memory.sv
// rtl/memory.sv - byte-wide single-port RAM with registered read, mirrored addressing, optional parity (MEMORY_PARITY_EN)
module memory #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  INIT_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        write,
    input  logic [7:0]  in,
`ifdef MEMORY_PARITY_EN
    output logic        parity_err,
`endif
    output logic [7:0]  out
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEMORY_PARITY_EN
    localparam int WORD_W = 9;
`else
    localparam int WORD_W = 8;
`endif

    // Zero-initialised so unwritten locations never read back as X in simulation.
    logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic [ADDR_W-1:0] idx;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_d;
    logic [7:0]        out_q;
    logic              unused_addr;

    assign idx         = addr[ADDR_W-1:0];
    assign unused_addr = ^addr;
    assign rd_d        = mem_q[idx];

`ifdef MEMORY_PARITY_EN
    assign wr_word = {^in, in};
`else
    assign wr_word = in;
`endif

    // Read-first: the output register samples the array before this edge's write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= INIT_BYTE;
        end else begin
            if (write) begin
                mem_q[idx] <= wr_word;
            end
            out_q <= rd_d[7:0];
        end
    end

    assign out = out_q;

`ifdef MEMORY_PARITY_EN
    logic parity_err_q;

    // Stored bit is even parity of the data, so the XOR of all nine bits is zero when intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= ^rd_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed self-checking bench for memory (ADDR_W=11, mirrored)
module tb_memory;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic        write;
    logic [7:0]  in;
    logic [7:0]  out;
`ifdef MEMORY_PARITY_EN
    logic        parity_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    memory #(
        .ADDR_W   (11),
        .INIT_BYTE(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .write     (write),
        .in        (in),
`ifdef MEMORY_PARITY_EN
        .parity_err(parity_err),
`endif
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [15:0] a, input logic [7:0] d);
        write = w;
        addr  = a;
        in    = d;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 16'h0010, 8'hAA);

        // Reset held with a write pending: output stays at INIT_BYTE, write discarded.
        #1;
        check("rst_t0", out, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold", out, 8'h00);
        end
        reset = 1'b1;
        drive(1'b0, 16'h0010, 8'h00);
        tick();
        check("rst_nowrite", out, 8'h00);

        // One-cycle read latency.
        drive(1'b1, 16'h0200, 8'h5C);
        tick();
        check("lat_wr_old", out, 8'h00);
        drive(1'b0, 16'h0200, 8'h00);
        tick();
        check("lat_rd", out, 8'h5C);

        // Read-during-write returns the old byte.
        drive(1'b1, 16'h0300, 8'h11);
        tick();
        drive(1'b1, 16'h0300, 8'h22);
        tick();
        check("rfirst_old", out, 8'h11);
        drive(1'b0, 16'h0300, 8'h00);
        tick();
        check("rfirst_new", out, 8'h22);

        // Mirroring every 2 KB.
        drive(1'b1, 16'h0005, 8'h77);
        tick();
        drive(1'b0, 16'h0805, 8'h00);
        tick();
        check("mirror_0805", out, 8'h77);
        drive(1'b0, 16'h1005, 8'h00);
        tick();
        check("mirror_1005", out, 8'h77);
        drive(1'b0, 16'hF805, 8'h00);
        tick();
        check("mirror_F805", out, 8'h77);

        // Back-to-back streaming write then read.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 16'h8000 + 16'(i), 8'(i));
            tick();
        end
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 16'h8000 + 16'(i), 8'h00);
            tick();
            check("stream_rd", out, 8'(i));
        end

        // Async reset mid-burst: first fill, then overwrite while out shows old data.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h0400 + 16'(i), 8'hA0 + 8'(i));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0400 + 16'(i), 8'hB0 + 8'(i));
            tick();
            check("burst2_old", out, 8'hA0 + 8'(i));
        end
        drive(1'b1, 16'h0404, 8'hB4);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_now", out, 8'h00);
        tick();
        check("async_rst_edge", out, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0400 + 16'(i), 8'h00);
            tick();
            check("post_rst_kept", out, 8'hB0 + 8'(i));
        end
        drive(1'b0, 16'h0404, 8'h00);
        tick();
        check("post_rst_discard", out, 8'hA4);
        drive(1'b0, 16'h0200, 8'h00);
        tick();
        check("post_rst_0200", out, 8'h5C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
